// File: rtl/lifo_pkg.sv
// Shared definitions for the arbitrated LIFO: default sizes, op encoding
// and controller states.
package lifo_pkg;

    localparam int LIFO_WIDTH = 4;
    localparam int LIFO_DEPTH = 4;

    typedef enum logic {
        PUSH = 1'b0,
        POP  = 1'b1
    } op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/lifo_core.sv
// Stack storage with occupancy counter and empty/full status.
// Entries above the top are always held at zero.
module lifo_core
    import lifo_pkg::*;
#(
    parameter int WIDTH = LIFO_WIDTH,
    parameter int DEPTH = LIFO_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             clr_i,
    input  logic [AW-1:0]    clr_idx_i,
    input  logic             clr_lvl_i,
    output logic [WIDTH-1:0] top_o,
    output logic [LW-1:0]    level_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_d;
    logic [LW-1:0]    top_l;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_idx;

    assign top_l   = level_q - LW'(1);
    assign top_idx = top_l[AW-1:0];
    assign wr_idx  = level_q[AW-1:0];

    always_comb begin
        level_d = level_q;
        if (clr_lvl_i) begin
            level_d = '0;
        end else if (push_i) begin
            level_d = level_q + LW'(1);
        end else if (pop_i) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            level_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            level_q <= level_d;
            if (clr_i) begin
                mem_q[clr_idx_i] <= '0;
            end
            if (push_i) begin
                mem_q[wr_idx] <= din_i;
            end
            if (pop_i) begin
                mem_q[top_idx] <= '0;
            end
        end
    end

    assign top_o   = mem_q[top_idx];
    assign level_o = level_q;
    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));

endmodule

// File: rtl/lifo_arbiter.sv
// Two-port round-robin front end for a LIFO, with a sequential flush
// that zeroes one entry per cycle and a saturating reject counter.
module lifo_arbiter
    import lifo_pkg::*;
#(
    parameter int WIDTH = LIFO_WIDTH,
    parameter int DEPTH = LIFO_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             rw0,
    input  logic             rw1,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    input  logic             flush,
    output logic             gnt0,
    output logic             gnt1,
    output logic             err0,
    output logic             err1,
    output logic [WIDTH-1:0] dout,
    output logic             dvalid0,
    output logic             dvalid1,
    output logic             empty,
    output logic             full,
    output logic [LW-1:0]    level,
    output logic             busy,
    output logic [7:0]       err_cnt
);

    localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

    state_e           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             last_q, last_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       err_q, err_d;
    logic [1:0]       dv_q, dv_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [7:0]       ecnt_q, ecnt_d;

    logic             m0, m1, sel1, ok;
    op_e              op;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] top;
    logic             push, pop, clr, clr_lvl;
    logic             is_empty, is_full;

    // A port in its grant cycle is masked; last_q=1 means port 1 won last.
    assign m0    = req0 & ~gnt_q[0];
    assign m1    = req1 & ~gnt_q[1];
    assign sel1  = m1 & (~m0 | ~last_q);
    assign op    = sel1 ? op_e'(rw1) : op_e'(rw0);
    assign wdata = sel1 ? din1 : din0;
    assign ok    = (op == POP) ? ~is_empty : ~is_full;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        gnt_d   = '0;
        err_d   = '0;
        dv_d    = '0;
        dout_d  = '0;
        ecnt_d  = ecnt_q;
        push    = 1'b0;
        pop     = 1'b0;
        clr     = 1'b0;
        clr_lvl = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end else if (m0 | m1) begin
                    last_d      = sel1;
                    gnt_d[sel1] = 1'b1;
                    if (ok) begin
                        push       = (op == PUSH);
                        pop        = (op == POP);
                        dv_d[sel1] = (op == POP);
                        dout_d     = (op == POP) ? top : '0;
                    end else begin
                        err_d[sel1] = 1'b1;
                        if (ecnt_q != 8'hFF) begin
                            ecnt_d = ecnt_q + 8'd1;
                        end
                    end
                end
            end
            FLUSH: begin
                clr   = 1'b1;
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == CNT_LAST) begin
                    clr_lvl = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            gnt_q   <= '0;
            err_q   <= '0;
            dv_q    <= '0;
            dout_q  <= '0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            err_q   <= err_d;
            dv_q    <= dv_d;
            dout_q  <= dout_d;
            ecnt_q  <= ecnt_d;
        end
    end

    lifo_core #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_core (
        .clk      (clk),
        .Rst      (Rst),
        .push_i   (push),
        .pop_i    (pop),
        .din_i    (wdata),
        .clr_i    (clr),
        .clr_idx_i(cnt_q),
        .clr_lvl_i(clr_lvl),
        .top_o    (top),
        .level_o  (level),
        .empty_o  (is_empty),
        .full_o   (is_full)
    );

    assign gnt0    = gnt_q[0];
    assign gnt1    = gnt_q[1];
    assign err0    = err_q[0];
    assign err1    = err_q[1];
    assign dvalid0 = dv_q[0];
    assign dvalid1 = dv_q[1];
    assign dout    = dout_q;
    assign empty   = is_empty;
    assign full    = is_full;
    assign busy    = (state_q == FLUSH);
    assign err_cnt = ecnt_q;

endmodule

// File: tb/tb_lifo_arbiter.sv
// Bench for lifo_arbiter: directed scenarios plus random traffic checked
// against a queue-based stack model.
module tb_lifo_arbiter;
    import lifo_pkg::*;

    localparam int W  = 4;
    localparam int D  = 4;
    localparam int LW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          Rst;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic          rw0 = 1'b0, rw1 = 1'b0;
    logic [W-1:0]  din0 = '0, din1 = '0;
    logic          flush = 1'b0;
    logic          gnt0, gnt1, err0, err1;
    logic [W-1:0]  dout;
    logic          dvalid0, dvalid1, empty, full, busy;
    logic [LW-1:0] level;
    logic [7:0]    err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    int stk[$];
    int fl_left;
    bit mlast;
    int m_ecnt;
    bit e_gnt[2];
    bit e_err[2];
    bit e_dv[2];
    int e_dout;

    always #5 clk = ~clk;

    lifo_arbiter #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .Rst(Rst),
        .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
        .din0(din0), .din1(din1), .flush(flush),
        .gnt0(gnt0), .gnt1(gnt1), .err0(err0), .err1(err1),
        .dout(dout), .dvalid0(dvalid0), .dvalid1(dvalid1),
        .empty(empty), .full(full), .level(level),
        .busy(busy), .err_cnt(err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        stk.delete();
        fl_left = 0;
        mlast   = 1'b1;
        m_ecnt  = 0;
        e_dout  = 0;
        for (int p = 0; p < 2; p++) begin
            e_gnt[p] = 1'b0;
            e_err[p] = 1'b0;
            e_dv[p]  = 1'b0;
        end
    endtask

    // One clock edge of the reference stack.
    task automatic model_edge();
        bit m[2];
        bit rw[2];
        int dn[2];
        int w;
        bit rej;
        m[0]  = req0 && !e_gnt[0];
        m[1]  = req1 && !e_gnt[1];
        rw[0] = rw0;
        rw[1] = rw1;
        dn[0] = int'(din0);
        dn[1] = int'(din1);
        for (int p = 0; p < 2; p++) begin
            e_gnt[p] = 1'b0;
            e_err[p] = 1'b0;
            e_dv[p]  = 1'b0;
        end
        e_dout = 0;
        rej    = 1'b0;
        if (fl_left > 0) begin
            fl_left--;
            if (fl_left == 0) stk.delete();
        end else if (flush) begin
            fl_left = D;
        end else if (m[0] || m[1]) begin
            if (m[0] && m[1]) w = mlast ? 0 : 1;
            else              w = m[1] ? 1 : 0;
            mlast    = (w == 1);
            e_gnt[w] = 1'b1;
            if (rw[w] == 1'b0) begin
                if (stk.size() < D) stk.push_back(dn[w]);
                else                rej = 1'b1;
            end else begin
                if (stk.size() > 0) begin
                    e_dout  = stk.pop_back();
                    e_dv[w] = 1'b1;
                end else begin
                    rej = 1'b1;
                end
            end
            if (rej) begin
                e_err[w] = 1'b1;
                if (m_ecnt < 255) m_ecnt++;
            end
        end
    endtask

    task automatic check_all();
        chk("gnt0", gnt0, e_gnt[0]);
        chk("gnt1", gnt1, e_gnt[1]);
        chk("err0", err0, e_err[0]);
        chk("err1", err1, e_err[1]);
        chk("dvalid0", dvalid0, e_dv[0]);
        chk("dvalid1", dvalid1, e_dv[1]);
        chk("dout", dout, e_dout);
        chk("level", level, stk.size());
        chk("empty", empty, stk.size() == 0);
        chk("full", full, stk.size() == D);
        chk("busy", busy, fl_left > 0);
        chk("err_cnt", err_cnt, m_ecnt);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        if (e_gnt[0]) req0 = 1'b0;
        if (e_gnt[1]) req1 = 1'b0;
    endtask

    task automatic issue(input int p, input bit op, input logic [W-1:0] d);
        int n;
        n = 0;
        if (e_gnt[p]) cyc();
        if (p == 0) begin
            req0 = 1'b1; rw0 = op; din0 = d;
        end else begin
            req1 = 1'b1; rw1 = op; din1 = d;
        end
        do begin
            cyc();
            n++;
        end while (!e_gnt[p] && n < 20);
        chk("grant_wait", (p == 0) ? gnt0 : gnt1, 1'b1);
    endtask

    task automatic do_reset();
        #2;
        Rst  = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        flush = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_empty", empty, 1'b1);
        chk("rst_busy", busy, 1'b0);
        #3;
        Rst = 1'b1;
    endtask

    logic [W-1:0] fill_v [4];
    int bl;

    initial begin
        fill_v[0] = 4'h3; fill_v[1] = 4'h5;
        fill_v[2] = 4'h9; fill_v[3] = 4'hC;
        Rst = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("init_empty", empty, 1'b1);
        chk("init_level", level, 0);
        #6;
        Rst = 1'b1;
        cyc();

        for (int i = 0; i < 4; i++) begin
            issue(0, PUSH, fill_v[i]);
            chk("fill_level", level, i + 1);
        end
        chk("fill_full", full, 1'b1);

        issue(1, PUSH, 4'h1);
        chk("full_err1", err1, 1'b1);
        chk("full_level", level, 4);
        chk("full_errcnt", err_cnt, 1);

        if (e_gnt[1]) cyc();
        req0 = 1'b1; rw0 = POP;
        req1 = 1'b1; rw1 = POP;
        cyc();
        chk("rr_gnt0", gnt0, 1'b1);
        chk("rr_dout0", dout, 4'hC);
        chk("rr_dv0", dvalid0, 1'b1);
        cyc();
        chk("rr_gnt1", gnt1, 1'b1);
        chk("rr_dout1", dout, 4'h9);
        chk("rr_dv1", dvalid1, 1'b1);
        issue(0, POP, '0);
        chk("pop_dout5", dout, 4'h5);
        issue(0, POP, '0);
        chk("pop_dout3", dout, 4'h3);

        issue(1, POP, '0);
        chk("empty_err1", err1, 1'b1);
        chk("empty_dv1", dvalid1, 1'b0);
        chk("empty_dout", dout, 0);
        chk("empty_errcnt", err_cnt, 2);
        for (int i = 0; i < 256; i++) issue(0, POP, '0);
        chk("errcnt_sat", err_cnt, 255);

        issue(0, PUSH, 4'h1);
        issue(0, PUSH, 4'h2);
        issue(0, PUSH, 4'h4);
        chk("pre_flush_level", level, 3);
        if (e_gnt[0]) cyc();
        flush = 1'b1;
        req0 = 1'b1; rw0 = PUSH; din0 = 4'hA;
        cyc();
        flush = 1'b0;
        bl = 0;
        for (int i = 0; i < 10 && busy; i++) begin
            bl++;
            cyc();
        end
        chk("busy_len", bl, 4);
        chk("flush_level", level, 0);
        chk("flush_empty", empty, 1'b1);
        chk("flush_gnt_wait", gnt0, 1'b0);
        cyc();
        chk("flush_gnt0", gnt0, 1'b1);
        chk("flush_push_level", level, 1);

        if (e_gnt[0]) cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        cyc();
        chk("mid_flush_busy", busy, 1'b1);
        do_reset();
        chk("rst_flush_level", level, 0);
        issue(0, PUSH, 4'h7);
        chk("rst_push_level", level, 1);
        issue(0, POP, '0);
        chk("rst_pop_dout", dout, 4'h7);
        issue(0, PUSH, 4'h5);
        do_reset();
        chk("rst_mid_gnt0", gnt0, 1'b0);
        issue(1, PUSH, 4'h7);
        chk("rst2_level", level, 1);

        for (int k = 0; k < 1500; k++) begin
            if (!req0 && !e_gnt[0] && $urandom_range(0, 2) == 0) begin
                req0 = 1'b1;
                rw0  = 1'($urandom_range(0, 1));
                din0 = W'($urandom_range(0, 15));
            end
            if (!req1 && !e_gnt[1] && $urandom_range(0, 2) == 0) begin
                req1 = 1'b1;
                rw1  = 1'($urandom_range(0, 1));
                din1 = W'($urandom_range(0, 15));
            end
            flush = ($urandom_range(0, 39) == 0);
            cyc();
            if ($urandom_range(0, 299) == 0) do_reset();
        end
        flush = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lifo_arbiter.md
LIFO_ARBITER -- requirements
Module: lifo_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, number of stack entries (power of two).
REQ-003 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- Rst  in  1  reset; one clock, asynchronous, active-low.
- req0, req1  in  1  request from requester 0 and requester 1.
- rw0, rw1  in  1  operation: 0 = push, 1 = pop.
- din0, din1  in  WIDTH  push data.
- flush  in  1  clear-stack command, level-sampled.
- gnt0, gnt1  out  1  one-cycle grant pulse.
- err0, err1  out  1  one-cycle pulse with the grant when the op is rejected.
- dout  out  WIDTH  pop data.
- dvalid0, dvalid1  out  1  dout valid for requester 0 or 1.
- empty, full  out  1  stack status.
- level  out  log2(DEPTH)+1  occupancy, 0..DEPTH.
- busy  out  1  high while flushing.
- err_cnt  out  8  saturating count of rejected ops.

Function
REQ-004 The FSM SHALL have two states, IDLE and FLUSH.
REQ-005 In IDLE with flush=1, the FSM SHALL enter FLUSH at the next edge; flush SHALL take priority over requests sampled in the same cycle.
REQ-006 FLUSH SHALL zero one entry per cycle using counter 0..DEPTH-1, holding busy=1 throughout. After DEPTH cycles it SHALL set level=0 and return to IDLE.
REQ-007 No grants SHALL issue in FLUSH. Pending requests SHALL wait.
REQ-008 In IDLE, each edge SHALL arbitrate at most one request. The winner's op SHALL execute at that edge, and its gnt SHALL be high for the following cycle only.
REQ-009 Arbitration SHALL be round-robin via a last-winner pointer. On contention the port that did not win last SHALL be granted. The pointer SHALL update only on a grant; its reset value favours port 0.
REQ-010 A port whose gnt is currently high SHALL be ignored in arbitration that cycle. Requesters hold req until gnt and drop it in the gnt cycle.
REQ-011 Push with level<DEPTH SHALL write din to entry level, then increment level.
REQ-012 Pop with level>0 SHALL drive dout = entry level-1 and dvalid of the winner high in the gnt cycle. It SHALL then clear that entry to 0 and decrement level.
REQ-013 Push when full, or pop when empty, SHALL leave the stack unchanged. It SHALL still grant, and SHALL assert the winner's err in the gnt cycle. dvalid SHALL stay low and dout SHALL be 0.
REQ-014 Each rejection SHALL increment err_cnt, saturating at 255 with no wrap.
REQ-015 empty SHALL equal (level==0) and full SHALL equal (level==DEPTH), both registered-consistent with level.
REQ-016 dout SHALL hold 0 in every cycle without a dvalid.
REQ-017 A flush asserted while a gnt pulse is high SHALL NOT suppress that pulse or its dvalid/err.

Reset
REQ-018 Rst low SHALL immediately set:
- state = IDLE, level = 0, all entries = 0;
- gnt, err, dvalid = 0, dout = 0;
- empty = 1, full = 0, busy = 0;
- err_cnt = 0, pointer = favour port 0.
REQ-019 Reset asserted mid-FLUSH or mid-grant SHALL abort the operation. The first edge after deassertion SHALL behave as IDLE from empty.

Structure
REQ-020 Package lifo_pkg SHALL hold the WIDTH/DEPTH defaults, the op encoding (PUSH=0, POP=1) and the FSM state enumeration.
REQ-021 The storage array, level pointer and empty/full logic SHALL be sub-module lifo_core. lifo_arbiter SHALL contain arbitration, FSM, flush counter and err_cnt.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Port 0 pushes 0x3, 0x5, 0x9, 0xC -> four gnt0 pulses, level 1,2,3,4, full=1 after the fourth.
- Fifth push 0x1 on port 1 when full -> gnt1+err1 together, level stays 4, err_cnt=1.
- Simultaneous req0 and req1 pops after the fill -> gnt0 first (dout=0xC, dvalid0), then gnt1 (dout=0x9, dvalid1).
- Pop on empty -> err pulse, dvalid low, dout=0, err_cnt increments; 256 such pops -> err_cnt holds 255.
- flush with level=3 and req0 pending -> busy high exactly 4 cycles, no grants, then level=0 and empty=1; gnt0 issues the cycle after busy falls.
- Rst pulsed low mid-FLUSH and mid-push -> all outputs at reset values immediately; a next push of 0x7 gives level=1 and a following pop returns 0x7.
